// File: rtl/edge_evt_arbiter_if.sv
// edge_evt_arbiter_if: event offer handshake (valid/index from arbiter, ready from consumer)
interface edge_evt_arbiter_if #(parameter int IDX_W = 2);
  logic             o_EVT_VALID;
  logic [IDX_W-1:0] o_EVT_IDX;
  logic             i_EVT_READY;
  modport master (output o_EVT_VALID, output o_EVT_IDX, input i_EVT_READY);
  modport slave  (input o_EVT_VALID, input o_EVT_IDX, output i_EVT_READY);
endinterface

// File: rtl/edge_evt_arbiter.sv
// edge_evt_arbiter: per-source rising-edge capture, pending/overrun flags, round-robin event offer (ports: i_CLK, i_RST async low, i_DATA, i_ENABLE, evt handshake, o_PENDING, o_OVERRUN, i_CLR_OVR)
module edge_evt_arbiter #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic [N_SRC-1:0]   i_DATA,
  input  logic               i_ENABLE,
  edge_evt_arbiter_if.master evt,
  output logic [N_SRC-1:0]   o_PENDING,
  output logic [N_SRC-1:0]   o_OVERRUN,
  input  logic               i_CLR_OVR
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t             state_q, state_d;
  logic [N_SRC-1:0]   q1_q, q1_d, q2_q, q2_d, pend_q, pend_d, ovr_q, ovr_d;
  logic [N_SRC-1:0]   rise, clr;
  logic [IDX_W-1:0]   idx_q, idx_d, last_q, last_d, win, cand;
  logic               accept;
  always_comb begin
    q1_d   = i_DATA;
    q2_d   = q1_q;
    rise   = q1_q & ~q2_q;
    accept = (state_q == OFFER) && evt.i_EVT_READY;
    clr    = accept ? (N_SRC'(1) << idx_q) : '0;
    pend_d = (pend_q & ~clr) | rise;
    ovr_d  = (i_CLR_OVR ? '0 : ovr_q) | (rise & pend_q & ~clr);
    win    = '0;
    cand   = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % N_SRC);
      win  = pend_q[cand] ? cand : win;
    end
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      state_d = (i_ENABLE && |pend_q) ? OFFER : IDLE;
      idx_d   = (i_ENABLE && |pend_q) ? win : idx_q;
    end else if (evt.i_EVT_READY) begin
      state_d = IDLE;
      last_d  = idx_q;
    end
  end
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      q1_q    <= '0;
      q2_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_SRC - 1);
    end else begin
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
  assign evt.o_EVT_VALID = (state_q == OFFER);
  assign evt.o_EVT_IDX   = idx_q;
  assign o_PENDING       = pend_q;
  assign o_OVERRUN       = ovr_q;
endmodule

// File: tb/tb_edge_evt_arbiter.sv
// tb_edge_evt_arbiter: table-driven check of edge capture, round-robin order, overrun and reset behaviour
module tb_edge_evt_arbiter;
  typedef struct {
    logic       rst;
    logic [3:0] data;
    logic       en;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] idx;
    logic [3:0] pend;
    logic [3:0] ovr;
  } vec_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [3:0] data = '0;
  logic       en = 1;
  logic       clr = 0;
  logic [3:0] pend, ovr;
  int         vectors = 0;
  int         miscompares = 0;
  vec_t       vecs[$];
  edge_evt_arbiter_if #(.IDX_W(2)) evt ();
  edge_evt_arbiter #(.N_SRC(4), .IDX_W(2)) dut (
    .i_CLK(clk), .i_RST(rst_n), .i_DATA(data), .i_ENABLE(en), .evt(evt),
    .o_PENDING(pend), .o_OVERRUN(ovr), .i_CLR_OVR(clr)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [3:0] d, input logic e, input logic rd, input logic c,
                     input logic v, input logic [1:0] i, input logic [3:0] p, input logic [3:0] o);
    vec_t t;
    t.rst = r; t.data = d; t.en = e; t.rdy = rd; t.clr = c;
    t.v = v; t.idx = i; t.pend = p; t.ovr = o;
    vecs.push_back(t);
  endtask
  task automatic chk(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, nm, act, exp);
    end
  endtask
  task automatic chk_all(input int row, input logic v, input logic [1:0] i, input logic [3:0] p, input logic [3:0] o);
    vectors++;
    chk("valid", row, {3'b0, evt.o_EVT_VALID}, {3'b0, v});
    chk("idx", row, {2'b0, evt.o_EVT_IDX}, {2'b0, i});
    chk("pending", row, pend, p);
    chk("overrun", row, ovr, o);
  endtask
  initial begin
    evt.i_EVT_READY = 1;
    // single source pulse, ready high
    add(1,4'b0100,1,1,0, 0,0,4'b0000,4'b0000);
    add(1,4'b0100,1,1,0, 0,0,4'b0100,4'b0000);
    add(1,4'b0100,1,1,0, 1,2,4'b0100,4'b0000);
    add(1,4'b0000,1,1,0, 0,2,4'b0000,4'b0000);
    add(1,4'b0000,1,1,0, 0,2,4'b0000,4'b0000);
    add(0,4'b0000,1,1,0, 0,0,4'b0000,4'b0000);
    // all four rise together: order 0,1,2,3
    add(1,4'b1111,1,1,0, 0,0,4'b0000,4'b0000);
    add(1,4'b1111,1,1,0, 0,0,4'b1111,4'b0000);
    add(1,4'b1111,1,1,0, 1,0,4'b1111,4'b0000);
    add(1,4'b1111,1,1,0, 0,0,4'b1110,4'b0000);
    add(1,4'b1111,1,1,0, 1,1,4'b1110,4'b0000);
    add(1,4'b1111,1,1,0, 0,1,4'b1100,4'b0000);
    add(1,4'b1111,1,1,0, 1,2,4'b1100,4'b0000);
    add(1,4'b1111,1,1,0, 0,2,4'b1000,4'b0000);
    add(1,4'b1111,1,1,0, 1,3,4'b1000,4'b0000);
    add(1,4'b0000,1,1,0, 0,3,4'b0000,4'b0000);
    add(1,4'b0000,1,1,0, 0,3,4'b0000,4'b0000);
    // sources 1 and 3 with last=3: order 1 then 3
    add(1,4'b1010,1,1,0, 0,3,4'b0000,4'b0000);
    add(1,4'b1010,1,1,0, 0,3,4'b1010,4'b0000);
    add(1,4'b1010,1,1,0, 1,1,4'b1010,4'b0000);
    add(1,4'b1010,1,1,0, 0,1,4'b1000,4'b0000);
    add(1,4'b1010,1,1,0, 1,3,4'b1000,4'b0000);
    add(1,4'b0000,1,1,0, 0,3,4'b0000,4'b0000);
    add(1,4'b0000,1,1,0, 0,3,4'b0000,4'b0000);
    // overrun while ready held low, then clear
    add(1,4'b0010,1,0,0, 0,3,4'b0000,4'b0000);
    add(1,4'b0000,1,0,0, 0,3,4'b0010,4'b0000);
    add(1,4'b0010,1,0,0, 1,1,4'b0010,4'b0000);
    add(1,4'b0010,1,0,0, 1,1,4'b0010,4'b0010);
    add(1,4'b0000,1,1,0, 0,1,4'b0000,4'b0010);
    add(1,4'b0000,1,1,1, 0,1,4'b0000,4'b0000);
    // rise coinciding with accept of same source
    add(1,4'b0010,1,0,0, 0,1,4'b0000,4'b0000);
    add(1,4'b0000,1,0,0, 0,1,4'b0010,4'b0000);
    add(1,4'b0000,1,0,0, 1,1,4'b0010,4'b0000);
    add(1,4'b0010,1,0,0, 1,1,4'b0010,4'b0000);
    add(1,4'b0000,1,1,0, 0,1,4'b0010,4'b0000);
    add(1,4'b0000,1,1,0, 1,1,4'b0010,4'b0000);
    add(1,4'b0000,1,1,0, 0,1,4'b0000,4'b0000);
    // enable gating and offer hold while enable drops
    add(1,4'b1000,0,1,0, 0,1,4'b0000,4'b0000);
    add(1,4'b1000,0,1,0, 0,1,4'b1000,4'b0000);
    add(1,4'b1000,0,1,0, 0,1,4'b1000,4'b0000);
    add(1,4'b1000,1,0,0, 1,3,4'b1000,4'b0000);
    add(1,4'b0000,0,0,0, 1,3,4'b1000,4'b0000);
    add(1,4'b0000,0,0,0, 1,3,4'b1000,4'b0000);
    add(1,4'b0000,0,1,0, 0,3,4'b0000,4'b0000);
    add(1,4'b0000,1,1,0, 0,3,4'b0000,4'b0000);
    // input high through reset release
    add(0,4'b0001,1,0,0, 0,0,4'b0000,4'b0000);
    add(1,4'b0001,1,0,0, 0,0,4'b0000,4'b0000);
    add(1,4'b0001,1,0,0, 0,0,4'b0001,4'b0000);
    add(1,4'b0001,1,0,0, 1,0,4'b0001,4'b0000);
    add(1,4'b0000,1,0,0, 1,0,4'b0001,4'b0000);
    add(1,4'b0001,1,0,0, 1,0,4'b0001,4'b0000);
    add(1,4'b0001,1,0,0, 1,0,4'b0001,4'b0001);
    repeat (3) @(posedge clk);
    #1 chk_all(-1, 0, 0, 4'b0000, 4'b0000);
    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      rst_n = vecs[r].rst;
      data = vecs[r].data;
      en = vecs[r].en;
      evt.i_EVT_READY = vecs[r].rdy;
      clr = vecs[r].clr;
      @(posedge clk);
      #1 chk_all(r, vecs[r].v, vecs[r].idx, vecs[r].pend, vecs[r].ovr);
    end
    // asynchronous reset in the middle of an offer
    @(negedge clk);
    clr = 0;
    #2 rst_n = 0;
    #1 chk_all(1000, 0, 0, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1 chk_all(1001, 0, 0, 4'b0000, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/edge_evt_arbiter.md
# edge_evt_arbiter

Collects rising-edge events from several asynchronous-looking level inputs (buttons, RF status lines) and serialises them onto one event port toward the ZigBee control FSM. Each source gets its own two-flop one-shot edge detector and a pending flag. A round-robin arbiter with a valid/ready handshake shares the single downstream event consumer fairly, and per-source sticky overrun flags record edges lost while an event was still pending.

## Interface
- N_SRC, default 4: number of level sources (2..16).
- IDX_W, default 2: width of source index; must equal ceil(log2(N_SRC)).

- i_CLK  in  1  single system clock; all logic on rising edge.
- i_RST  in  1  asynchronous, active-low reset: asserted low, clears all state immediately; released synchronously by the design environment.
- i_DATA  in  N_SRC  raw level inputs, one per source.
- i_ENABLE  in  1  high allows new offers; edge capture runs regardless.
- o_EVT_VALID  out  1  an event is offered.
- o_EVT_IDX  out  IDX_W  source index of the offered event.
- i_EVT_READY  in  1  consumer accepts when high together with o_EVT_VALID.
- o_PENDING  out  N_SRC  per-source pending flags.
- o_OVERRUN  out  N_SRC  sticky per-source lost-edge flags.
- i_CLR_OVR  in  1  one-cycle pulse clearing all o_OVERRUN bits.

## Operation
- Per source i: q1[i] <= i_DATA[i]; q2[i] <= q1[i]; rise[i] = q1[i] & ~q2[i] (combinational, one cycle wide).
- rise[i] sets pending[i] at the next edge.
- rise[i] while pending[i] already set and not cleared the same cycle: overrun[i] set, pending[i] stays 1 (events do not queue beyond one per source).
- rise[i] in the same cycle pending[i] is being cleared by an accept: pending[i] remains 1, no overrun.
- i_CLR_OVR clears all overrun bits; a new overrun in the same cycle wins (bit stays 1).
- Round-robin pointer last (IDX_W bits): index of the last accepted source. Winner is the first pending source searching last+1, last+2, ... wrapping modulo N_SRC.
- FSM, two states:
  - IDLE: o_EVT_VALID=0. If i_ENABLE and any pending: latch winner into o_EVT_IDX, go OFFER.
  - OFFER: o_EVT_VALID=1, o_EVT_IDX held stable. On i_EVT_READY: clear pending[o_EVT_IDX], last <= o_EVT_IDX, go IDLE. Otherwise stay.
- An offer is never retracted or changed: i_ENABLE dropping in OFFER has no effect until accept.
- Sources becoming pending during OFFER do not change the offered index.

## Timing
- Reset values: q1=q2=0, pending=0, overrun=0, state IDLE, o_EVT_VALID=0, o_EVT_IDX=0, last=N_SRC-1 (source 0 wins first).
- Because q1/q2 reset to 0, an input already high at reset release produces one edge event.
- Latency: i_DATA rises before edge E0 -> rise high after E0 -> pending after E1 -> o_EVT_VALID high after E2.
- Accept at edge Ea (valid & ready high before Ea): o_EVT_VALID low and pending cleared after Ea. The next offer appears no earlier than after Ea+1. Maximum throughput is one event per 2 cycles.
- Pulse on i_DATA shorter than one clock may be missed; 1-cycle high sampled at one edge yields exactly one event.
- Level held high yields exactly one event; a new event requires low for at least one sampled edge.
- Reset asserted mid-OFFER: o_EVT_VALID drops immediately (asynchronously), all pending/overrun lost.

## Test plan
- Reset, then pulse i_DATA[2] high 3 cycles, i_EVT_READY=1 -> o_EVT_VALID high exactly 1 cycle, 2 cycles after first sampling edge, o_EVT_IDX=2; o_PENDING returns to 0.
- i_DATA[0..3] all rise same cycle, ready=1 -> events in order 0,1,2,3, each valid 1 cycle, one idle cycle between; then source 1 and 3 rise together -> order 1,3? no: last=3, so order 1 then 3 is correct.
- Hold ready=0, source 1 rises, drops, rises again -> o_OVERRUN=4'b0010, single event idx 1 on release of ready; i_CLR_OVR pulse -> o_OVERRUN=0.
- Source 1 rise coinciding with accept of idx 1 -> second event idx 1 offered, o_OVERRUN stays 0.
- i_ENABLE=0 with source 3 rise -> o_PENDING[3]=1, no valid; raise i_ENABLE -> idx 3 offered next cycle; drop i_ENABLE during OFFER -> offer held until ready.
- i_DATA[0] high through reset release -> one event idx 0; assert i_RST low mid-OFFER -> o_EVT_VALID=0 immediately, all flags 0.
